// File: rtl/flag_branch_resolver_pkg.sv
// Shared types for the flag producer/consumer path: condition codes, flag
// vector layout and bit positions used by both the ALU and the branch resolver.
package flag_branch_resolver_pkg;

  typedef logic [1:0] flags_t;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;

  typedef enum logic [2:0] {
    CondAlways = 3'd0,
    CondEq     = 3'd1,
    CondNe     = 3'd2,
    CondLt     = 3'd3,
    CondGe     = 3'd4,
    CondGt     = 3'd5,
    CondLe     = 3'd6,
    CondNever  = 3'd7
  } cond_e;

endpackage

// File: rtl/flag_cond_eval.sv
// Pure combinational evaluation of a condition code against a flag vector;
// shared by branch resolution and any predicated-execution logic.
module flag_cond_eval
  import flag_branch_resolver_pkg::*;
(
  input  cond_e  cond_i,
  input  flags_t flags_i,
  output logic   taken_o
);

  logic z;
  logic n;

  assign z = flags_i[FLAG_Z];
  assign n = flags_i[FLAG_N];

  always_comb begin
    taken_o = 1'b0;
    unique case (cond_i)
      CondAlways: taken_o = 1'b1;
      CondEq:     taken_o = z;
      CondNe:     taken_o = ~z;
      CondLt:     taken_o = n;
      CondGe:     taken_o = ~n;
      CondGt:     taken_o = ~z & ~n;
      CondLe:     taken_o = z | n;
      CondNever:  taken_o = 1'b0;
      default:    taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_resolver.sv
// Latches ALU zero/negative flags, counts in-flight flag setters and resolves
// conditional branches once every older flag write has landed.
module flag_branch_resolver
  import flag_branch_resolver_pkg::*;
#(
  parameter int unsigned MAX_PEND = 3,
  localparam int unsigned CW      = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fs_issue,
  input  logic          flags_we,
  input  logic [1:0]    flags_in,
  input  logic          flush,
  input  logic          br_valid,
  input  logic [2:0]    br_cond,
  output logic          br_stall,
  output logic          br_done,
  output logic          br_taken,
  output logic [1:0]    flags_q,
  output logic [CW-1:0] pend_cnt,
  output logic          err
);

  localparam logic [CW-1:0] PendMax = CW'(MAX_PEND);
  localparam logic [CW-1:0] PendOne = CW'(1);

  flags_t        flags_d;
  logic [CW-1:0] pend_d;
  logic          err_d;
  logic          br_done_d;
  logic          br_taken_d;

  flags_t        flags_eff;
  logic          pend_zero;
  logic          we_valid;
  logic [CW-1:0] rem;
  logic          accept;
  logic          cond_taken;
  cond_e         cond;

  assign pend_zero = (pend_cnt == '0);
  assign we_valid  = flags_we & ~pend_zero;
  assign rem       = pend_cnt - CW'(we_valid);

  // A setter issued alongside the branch is younger, so only rem matters here.
  assign br_stall = br_valid & (rem != '0) & ~flush;
  assign accept   = br_valid & ~br_stall & ~flush;

  // The final outstanding write is forwarded so the branch resolves this cycle.
  assign flags_eff = (flags_we && pend_cnt == PendOne) ? flags_t'(flags_in) : flags_t'(flags_q);
  assign cond      = cond_e'(br_cond);

  flag_cond_eval u_cond_eval (
    .cond_i  (cond),
    .flags_i (flags_eff),
    .taken_o (cond_taken)
  );

  always_comb begin
    flags_d = flags_we ? flags_t'(flags_in) : flags_t'(flags_q);
    pend_d  = pend_cnt;
    err_d   = err;

    // Writeback with nothing outstanding is an underflow even during flush.
    if (flags_we && pend_zero) begin
      err_d = 1'b1;
    end

    if (flush) begin
      pend_d = '0;
    end else begin
      unique case ({fs_issue, flags_we})
        2'b10: begin
          if (pend_cnt == PendMax) begin
            err_d = 1'b1;
          end else begin
            pend_d = pend_cnt + PendOne;
          end
        end
        2'b01: begin
          if (!pend_zero) begin
            pend_d = pend_cnt - PendOne;
          end
        end
        default: pend_d = pend_cnt;
      endcase
    end

    br_done_d  = accept;
    br_taken_d = accept ? cond_taken : br_taken;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q  <= 2'b00;
      pend_cnt <= '0;
      err      <= 1'b0;
      br_done  <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      pend_cnt <= pend_d;
      err      <= err_d;
      br_done  <= br_done_d;
      br_taken <= br_taken_d;
    end
  end

endmodule

// File: tb/tb_flag_branch_resolver.sv
// Directed self-checking bench for flag_branch_resolver.
module tb_flag_branch_resolver;

  logic       clk;
  logic       rst;
  logic       fs_issue;
  logic       flags_we;
  logic [1:0] flags_in;
  logic       flush;
  logic       br_valid;
  logic [2:0] br_cond;
  logic       br_stall;
  logic       br_done;
  logic       br_taken;
  logic [1:0] flags_q;
  logic [1:0] pend_cnt;
  logic       err;

  int checks;
  int failures;

  flag_branch_resolver #(
    .MAX_PEND (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fs_issue (fs_issue),
    .flags_we (flags_we),
    .flags_in (flags_in),
    .flush    (flush),
    .br_valid (br_valid),
    .br_cond  (br_cond),
    .br_stall (br_stall),
    .br_done  (br_done),
    .br_taken (br_taken),
    .flags_q  (flags_q),
    .pend_cnt (pend_cnt),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fs_issue = 1'b0;
    flags_we = 1'b0;
    flags_in = 2'b00;
    flush    = 1'b0;
    br_valid = 1'b0;
    br_cond  = 3'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (flags_q !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", flags_q); end
    checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL reset_pend got=%0d exp=0", pend_cnt); end
    checks++; if (br_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", br_done); end
    checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%b exp=0", br_taken); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_always();
    br_valid = 1'b1; br_cond = 3'd0;
    #1;
    checks++; if (br_stall !== 1'b0) begin failures++; $display("FAIL always_stall got=%b exp=0", br_stall); end
    tick();
    br_valid = 1'b0;
    checks++; if (br_done !== 1'b1) begin failures++; $display("FAIL always_done got=%b exp=1", br_done); end
    checks++; if (br_taken !== 1'b1) begin failures++; $display("FAIL always_taken got=%b exp=1", br_taken); end
    checks++; if (flags_q !== 2'b00) begin failures++; $display("FAIL always_flags got=%b exp=00", flags_q); end
    tick();
    checks++; if (br_done !== 1'b0) begin failures++; $display("FAIL always_pulse got=%b exp=0", br_done); end
  endtask

  task automatic test_eq_gt_back_to_back();
    fs_issue = 1'b1;
    tick();
    fs_issue = 1'b0; flags_we = 1'b1; flags_in = 2'b01;
    tick();
    flags_we = 1'b0;
    checks++; if (flags_q !== 2'b01) begin failures++; $display("FAIL eq_flags got=%b exp=01", flags_q); end
    checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL eq_pend got=%0d exp=0", pend_cnt); end
    br_valid = 1'b1; br_cond = 3'd1;
    tick();
    br_cond = 3'd5;
    checks++; if (br_done !== 1'b1) begin failures++; $display("FAIL eq_done got=%b exp=1", br_done); end
    checks++; if (br_taken !== 1'b1) begin failures++; $display("FAIL eq_taken got=%b exp=1", br_taken); end
    tick();
    br_valid = 1'b0;
    checks++; if (br_done !== 1'b1) begin failures++; $display("FAIL gt_done got=%b exp=1", br_done); end
    checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL gt_taken got=%b exp=0", br_taken); end
    tick();
  endtask

  task automatic test_stall_bypass();
    fs_issue = 1'b1;
    tick();
    fs_issue = 1'b0; br_valid = 1'b1; br_cond = 3'd3;
    #1;
    checks++; if (br_stall !== 1'b1) begin failures++; $display("FAIL sb_stall_c1 got=%b exp=1", br_stall); end
    tick();
    checks++; if (br_stall !== 1'b1) begin failures++; $display("FAIL sb_stall_c2 got=%b exp=1", br_stall); end
    checks++; if (br_done !== 1'b0) begin failures++; $display("FAIL sb_done_c2 got=%b exp=0", br_done); end
    tick();
    flags_we = 1'b1; flags_in = 2'b10;
    #1;
    checks++; if (br_stall !== 1'b0) begin failures++; $display("FAIL sb_stall_c3 got=%b exp=0", br_stall); end
    tick();
    flags_we = 1'b0; br_valid = 1'b0;
    checks++; if (br_done !== 1'b1) begin failures++; $display("FAIL sb_done_c4 got=%b exp=1", br_done); end
    checks++; if (br_taken !== 1'b1) begin failures++; $display("FAIL sb_taken_c4 got=%b exp=1", br_taken); end
    checks++; if (flags_q !== 2'b10) begin failures++; $display("FAIL sb_flags got=%b exp=10", flags_q); end
    checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL sb_pend got=%0d exp=0", pend_cnt); end
    tick();
  endtask

  task automatic test_two_setters();
    fs_issue = 1'b1;
    tick();
    tick();
    fs_issue = 1'b0; br_valid = 1'b1; br_cond = 3'd2;
    flags_we = 1'b1; flags_in = 2'b01;
    #1;
    checks++; if (br_stall !== 1'b1) begin failures++; $display("FAIL two_stall_first got=%b exp=1", br_stall); end
    tick();
    checks++; if (flags_q !== 2'b01) begin failures++; $display("FAIL two_flags_first got=%b exp=01", flags_q); end
    checks++; if (br_done !== 1'b0) begin failures++; $display("FAIL two_done_first got=%b exp=0", br_done); end
    checks++; if (pend_cnt !== 2'd1) begin failures++; $display("FAIL two_pend got=%0d exp=1", pend_cnt); end
    flags_in = 2'b00;
    #1;
    checks++; if (br_stall !== 1'b0) begin failures++; $display("FAIL two_stall_second got=%b exp=0", br_stall); end
    tick();
    flags_we = 1'b0; br_valid = 1'b0;
    checks++; if (br_done !== 1'b1) begin failures++; $display("FAIL two_done got=%b exp=1", br_done); end
    checks++; if (br_taken !== 1'b1) begin failures++; $display("FAIL two_taken_ne got=%b exp=1", br_taken); end
    tick();
  endtask

  task automatic test_flush();
    // NEVER first so a held br_taken is distinguishable from a new LE result.
    br_valid = 1'b1; br_cond = 3'd7;
    tick();
    br_valid = 1'b0;
    checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL never_taken got=%b exp=0", br_taken); end
    fs_issue = 1'b1;
    tick();
    tick();
    fs_issue = 1'b0; br_valid = 1'b1; br_cond = 3'd6;
    #1;
    checks++; if (br_stall !== 1'b1) begin failures++; $display("FAIL fl_stall_pre got=%b exp=1", br_stall); end
    flush = 1'b1; flags_we = 1'b1; flags_in = 2'b11;
    #1;
    checks++; if (br_stall !== 1'b0) begin failures++; $display("FAIL fl_stall_flush got=%b exp=0", br_stall); end
    tick();
    flush = 1'b0; flags_we = 1'b0;
    checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL fl_pend got=%0d exp=0", pend_cnt); end
    checks++; if (flags_q !== 2'b11) begin failures++; $display("FAIL fl_flags got=%b exp=11", flags_q); end
    checks++; if (br_done !== 1'b0) begin failures++; $display("FAIL fl_done got=%b exp=0", br_done); end
    checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL fl_taken_hold got=%b exp=0", br_taken); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL fl_err got=%b exp=0", err); end
    tick();
    br_valid = 1'b0;
    checks++; if (br_done !== 1'b1) begin failures++; $display("FAIL fl_done_after got=%b exp=1", br_done); end
    checks++; if (br_taken !== 1'b1) begin failures++; $display("FAIL fl_taken_le got=%b exp=1", br_taken); end
    tick();
  endtask

  task automatic test_limits();
    do_reset();
    fs_issue = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL lim_err_at3 got=%b exp=0", err); end
    tick();
    fs_issue = 1'b0;
    checks++; if (pend_cnt !== 2'd3) begin failures++; $display("FAIL lim_pend_sat got=%0d exp=3", pend_cnt); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL lim_err_ovf got=%b exp=1", err); end
    tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL lim_err_sticky got=%b exp=1", err); end

    do_reset();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL lim_err_rst got=%b exp=0", err); end
    flags_we = 1'b1; flags_in = 2'b10;
    tick();
    flags_we = 1'b0;
    checks++; if (flags_q !== 2'b10) begin failures++; $display("FAIL unf_flags got=%b exp=10", flags_q); end
    checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL unf_pend got=%0d exp=0", pend_cnt); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL unf_err got=%b exp=1", err); end

    do_reset();
    fs_issue = 1'b1;
    tick();
    tick();
    flags_we = 1'b1; flags_in = 2'b01;
    tick();
    fs_issue = 1'b0; flags_we = 1'b0;
    checks++; if (pend_cnt !== 2'd2) begin failures++; $display("FAIL both_pend got=%0d exp=2", pend_cnt); end
    checks++; if (flags_q !== 2'b01) begin failures++; $display("FAIL both_flags got=%b exp=01", flags_q); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL both_err got=%b exp=0", err); end
  endtask

  task automatic test_ordering_and_reset_drop();
    do_reset();
    // Setter issued with the branch is younger and must not stall it.
    fs_issue = 1'b1; br_valid = 1'b1; br_cond = 3'd4;
    #1;
    checks++; if (br_stall !== 1'b0) begin failures++; $display("FAIL ord_stall got=%b exp=0", br_stall); end
    tick();
    fs_issue = 1'b0;
    checks++; if (br_done !== 1'b1) begin failures++; $display("FAIL ord_done got=%b exp=1", br_done); end
    checks++; if (br_taken !== 1'b1) begin failures++; $display("FAIL ord_taken_ge got=%b exp=1", br_taken); end
    #1;
    checks++; if (br_stall !== 1'b1) begin failures++; $display("FAIL ord_stall_next got=%b exp=1", br_stall); end
    rst = 1'b1;
    tick();
    rst = 1'b0; br_valid = 1'b0;
    checks++; if (br_done !== 1'b0) begin failures++; $display("FAIL rst_drop_done got=%b exp=0", br_done); end
    checks++; if (pend_cnt !== 2'd0) begin failures++; $display("FAIL rst_drop_pend got=%0d exp=0", pend_cnt); end
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_always();
    test_eq_gt_back_to_back();
    test_stall_bypass();
    test_two_setters();
    test_flush();
    test_limits();
    test_ordering_and_reset_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flag_branch_resolver.md
Name: flag_branch_resolver

Overview:
- Consumer end of the ALU status flags: latches the zero/negative flags written back by flag-setting instructions and resolves conditional branches against them.
- Tracks in-flight flag-setting instructions with a pending counter. Stalls a branch until every older flag write has landed, with a same-cycle bypass of the final write.
- Sits between the execute/writeback stages (flag producer) and the fetch/PC logic (branch consumer).

Parameters:
- MAX_PEND, 3, maximum number of outstanding flag-setting instructions tracked.
- CW, $clog2(MAX_PEND+1), pending counter width (derived, not overridable).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- fs_issue  in  1  a flag-setting instruction enters the pipeline this cycle
- flags_we  in  1  flag writeback this cycle (oldest outstanding setter)
- flags_in  in  2  written flags: bit0 zero (Z), bit1 negative (N)
- flush  in  1  pipeline flush: kills all in-flight setters and any branch request
- br_valid  in  1  branch request; br_cond held stable while stalled
- br_cond  in  3  condition code
- br_stall  out  1  combinational: request cannot resolve this cycle
- br_done  out  1  registered one-cycle pulse: branch resolved
- br_taken  out  1  registered outcome; qualified by br_done
- flags_q  out  2  architectural flag register
- pend_cnt  out  CW  outstanding flag setters
- err  out  1  sticky: overflow or underflow of the pending counter

Behaviour:
- Reset: flags_q=2'b00, pend_cnt=0, br_done=0, br_taken=0, err=0. Asserting rst mid-operation drops a stalled branch; nothing resolves on the cycle after rst.
- Flag register: if flags_we, flags_q <= flags_in next edge. This also applies in a flush cycle, because a writeback is older than the flush.
- Pending counter, normal: +1 on fs_issue, -1 on flags_we. Both together leaves it unchanged.
- Pending counter, flush: pend_cnt <= 0. fs_issue in the same cycle is ignored.
- Overflow: fs_issue alone at pend_cnt==MAX_PEND leaves the count saturated and sets err.
- Underflow: flags_we at pend_cnt==0 still latches the flags, the count stays 0, and err is set.
- err is cleared only by rst.
- Ordering: fs_issue in the same cycle as br_valid is younger than the branch and never stalls it.
- Remaining writes: rem = pend_cnt - (flags_we && pend_cnt!=0).
- Stall: br_stall = br_valid && rem!=0 && !flush.
- Effective flags: flags_in when flags_we && pend_cnt==1 (bypass); otherwise flags_q.
- Resolution: br_valid && !br_stall && !flush gives br_done=1 at the next edge, and br_taken = cond(effective flags). Latency is 1 cycle from the non-stalled request.
- br_done is high for exactly one cycle per accepted request. The requester drops br_valid or presents a new branch after seeing br_done.
- With flush, no br_done next cycle and br_taken holds its old value.
- Condition codes:
  - 0 ALWAYS = 1
  - 1 EQ = Z
  - 2 NE = !Z
  - 3 LT = N
  - 4 GE = !N
  - 5 GT = !Z & !N
  - 6 LE = Z | N
  - 7 NEVER = 0
- Back-to-back: consecutive non-stalled requests each produce a br_done on the following cycle, giving a throughput of 1 per cycle.

Decomposition:
- Shared package:
  - cond_e enum: ALWAYS..NEVER encodings above.
  - Flag bit index constants: FLAG_Z=0, FLAG_N=1.
  - Flag vector typedef, flags_t = logic [1:0].
  - The flag-setting ALU uses the same bit constants.
- One combinational sub-module, flag_cond_eval (cond_e and flags_t in, taken out). It is reusable by any predicated-execution logic.

Test Plan:
- Reset, then br_valid=1, br_cond=ALWAYS, pend_cnt=0 -> br_stall=0; next cycle br_done=1, br_taken=1; flags_q=00.
- flags_we=1, flags_in=01, then br_cond=EQ -> br_taken=1. With br_cond=GT instead -> br_taken=0.
- Stall and bypass:
  - Stimulus: fs_issue on cycle 0; br_valid(LT) from cycle 1; flags_we with flags_in=10 on cycle 3.
  - Response: br_stall=1 on cycles 1–2, 0 on cycle 3; br_done=1 with br_taken=1 on cycle 4.
- Two setters in flight plus a branch:
  - First flags_we (Z=1): br_stall stays 1 and flags_q=01.
  - Second flags_we (Z=0,N=0): resolves via bypass; br_cond=NE gives br_taken=1.
- Flush mid-stall:
  - Stimulus: pend_cnt=2, br_valid held, flush=1 with flags_we=1, flags_in=11.
  - Response: pend_cnt=0 next cycle, flags_q=11, no br_done that cycle. The held request resolves the following cycle with LE -> taken=1.
- Counter limits:
  - 4 fs_issue pulses with MAX_PEND=3 -> pend_cnt=3, err=1.
  - After rst, flags_we at pend_cnt=0 -> flags latched, pend_cnt=0, err=1.
  - Simultaneous fs_issue and flags_we at pend_cnt=2 -> pend_cnt stays 2.
